// File: rtl/des_key_schedule.sv
// DES key schedule: PC-1 on start, then one rotate + PC-2 per cycle, filling
// sixteen 48-bit round-key slots in encrypt or reversed (decrypt) order.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for start; slots hold whatever the last run left
// S_RUN  | one C/D rotation and one slot write per cycle, r = 0..15
// S_DONE | all 16 slots written; done pulses, start here restarts at once
module des_key_schedule (
    input  logic         clk,
    input  logic         rst,
    input  logic [63:0]  key_in,
    input  logic         decrypt,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         keys_valid,
    output logic [767:0] round_keys
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    // DES bit numbering, bit 1 = MSB; parity bits 8,16,...,64 never selected
    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] o;
        logic [5:0]  src;
        logic [5:0]  dst;
        o = '0;
        for (int i = 0; i < 56; i++) begin
            src = 6'(64 - PC1_TBL[i]);
            dst = 6'(55 - i);
            o[dst] = k[src];
        end
        return o;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] o;
        logic [5:0]  src;
        logic [5:0]  dst;
        o = '0;
        for (int i = 0; i < 48; i++) begin
            src = 6'(56 - PC2_TBL[i]);
            dst = 6'(47 - i);
            o[dst] = cd[src];
        end
        return o;
    endfunction

    state_t         state_q;
    logic [27:0]    c_q, d_q;
    logic [3:0]     r_q;
    logic           dec_q;
    logic           busy_q, done_q, valid_q;
    logic [767:0]   keys_q;

    logic [55:0]    cd_load_d;
    logic [27:0]    c_rot_d, d_rot_d;
    logic [47:0]    sub_key_d;
    logic [3:0]     slot_d;
    logic [9:0]     base_d;
    logic           one_shift;

    // Rotation amount, rotated halves, PC-2 round key and its target slot
    always_comb begin
        cd_load_d = pc1(key_in);
        one_shift = (r_q == 4'd0) || (r_q == 4'd1) || (r_q == 4'd8) || (r_q == 4'd15);
        if (one_shift) begin
            c_rot_d = {c_q[26:0], c_q[27]};
            d_rot_d = {d_q[26:0], d_q[27]};
        end else begin
            c_rot_d = {c_q[25:0], c_q[27:26]};
            d_rot_d = {d_q[25:0], d_q[27:26]};
        end
        sub_key_d = pc2({c_rot_d, d_rot_d});
        slot_d    = dec_q ? (4'd15 - r_q) : r_q;
        base_d    = 10'(slot_d) * 10'd48;
    end

    // Sequencer FSM with registered outputs and slot storage
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            c_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            dec_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            keys_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        c_q     <= cd_load_d[55:28];
                        d_q     <= cd_load_d[27:0];
                        dec_q   <= decrypt;
                        r_q     <= '0;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    c_q                 <= c_rot_d;
                    d_q                 <= d_rot_d;
                    keys_q[base_d +: 48] <= sub_key_d;
                    r_q                 <= r_q + 4'd1;
                    if (r_q == 4'd15) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        valid_q <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign keys_valid = valid_q;
    assign round_keys = keys_q;

endmodule
